// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// Holds funct3 access codes, the grant-owner state and the legality check.
package dmem_arb_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_e;

  // Unsigned sizes only make sense for loads
  function automatic logic rw_legal(
    input logic       we,
    input logic [2:0] rw
  );
    logic st_ok;
    st_ok = rw inside {RW_B, RW_H, RW_W};
    return we ? st_ok : (st_ok || (rw inside {RW_BU, RW_HU}));
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Round-robin grant decision with bounded bus lock for requester 1.
// Tracks the last owner and how long requester 0 has been held off.
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       lock1,
  output logic [1:0] gnt
);

  arb_state_e state;
  logic       last;
  logic [3:0] lock_cnt;
  logic       lock_hit;

  assign lock_hit = (state == OWN1) && lock1 && req1
                 && (lock_cnt < 4'(MAX_LOCK));

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      unique case (1'b1)
        req0 && !req1: gnt = 2'b01;
        req1 && !req0: gnt = 2'b10;
        req0 && req1:  gnt = (lock_hit || !last) ? 2'b10 : 2'b01;
        default:       gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      unique case (1'b1)
        gnt[0]: begin
          state <= OWN0;
          last  <= 1'b0;
        end
        gnt[1]: begin
          state <= OWN1;
          last  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      // Count every grant that keeps a waiting requester 0 off the bus
      if (gnt[1] && lock1 && req0)
        lock_cnt <= (lock_cnt == 4'(MAX_LOCK)) ? lock_cnt
                                               : lock_cnt + 4'd1;
      else
        lock_cnt <= '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the LSU and a DMA/debug loader.
// Muxes the granted access, filters illegal sizes, registers load data.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [2:0]        m0_rw_type,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [2:0]        m1_rw_type,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_err,
  output logic              m1_err,
  output logic              mem_W_en,
  output logic              mem_R_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_RW_type,
  output logic [DATA_W-1:0] mem_WD,
  input  logic [DATA_W-1:0] mem_RD
);

  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [2:0]        sel_rw;
  logic              legal;
  logic [DATA_W-1:0] rdata;

  dmem_arb_pick #(
    .MAX_LOCK(MAX_LOCK)
  ) u_pick (
    .clk  (clk),
    .rst  (rst),
    .req0 (m0_req),
    .req1 (m1_req),
    .lock1(m1_lock),
    .gnt  (gnt)
  );

  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];
  assign any_gnt = |gnt;

  assign sel_we = gnt[1] ? m1_we      : m0_we;
  assign sel_rw = gnt[1] ? m1_rw_type : m0_rw_type;
  assign legal  = rw_legal(sel_we, sel_rw);

  assign mem_W_en    = any_gnt && legal && sel_we;
  assign mem_R_en    = any_gnt && legal && !sel_we;
  assign mem_addr    = !any_gnt ? '0 : gnt[1] ? m1_addr  : m0_addr;
  assign mem_WD      = !any_gnt ? '0 : gnt[1] ? m1_wdata : m0_wdata;
  assign mem_RW_type = any_gnt ? sel_rw : 3'b000;

  // One response register shared by both requesters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      rdata     <= '0;
    end else begin
      m0_rvalid <= gnt[0] && mem_R_en;
      m1_rvalid <= gnt[1] && mem_R_en;
      m0_err    <= gnt[0] && !legal;
      m1_err    <= gnt[1] && !legal;
      if (mem_R_en)
        rdata <= mem_RD;
    end
  end

  assign m0_rdata = rdata;
  assign m1_rdata = rdata;

endmodule
